// File: rtl/cnn_pool_window_pkg.sv
// cnn_pool_window_pkg: shared types and constants for the pooling window
// generator. Supplies defaults for the CNN configuration macros
// (KERNEL_SIZE, WINDOW_SIZE, POOL_LB_MAX_WIDTH, POOL_DIM_W, POOL_STRIDE_W)
// when the project config header has not already defined them.
// Optional feature macro used by the block: POOL_WINDOW_STRIDE_EN.
`ifndef KERNEL_SIZE
`define KERNEL_SIZE 3
`endif
`ifndef WINDOW_SIZE
`define WINDOW_SIZE 9
`endif
`ifndef POOL_LB_MAX_WIDTH
`define POOL_LB_MAX_WIDTH 224
`endif
`ifndef POOL_DIM_W
`define POOL_DIM_W 8
`endif
`ifndef POOL_STRIDE_W
`define POOL_STRIDE_W 2
`endif

package cnn_pool_window_pkg;
  localparam int KS       = `KERNEL_SIZE;
  localparam int WS       = `WINDOW_SIZE;
  localparam int PIX_W    = 32;
  localparam int STRIDE_W = `POOL_STRIDE_W;

  typedef logic [PIX_W-1:0] pix_t;
  // One window column: [0] = row r-2, [1] = row r-1, [2] = row r.
  typedef pix_t [2:0] col_t;

  // One-hot kernel code -> kernel size; 0 marks an unsupported code.
  function automatic logic [1:0] kdim(input logic [KS-1:0] oh);
    if (oh == KS'(2))      return 2'd2;
    else if (oh == KS'(4)) return 2'd3;
    else                   return 2'd0;
  endfunction
endpackage

// File: rtl/cnn_pool_window_if.sv
// cnn_pool_window_if: pixel stream in, window stream out.
//   in_valid/in_data/in_ready : raster pixel handshake
//   window_stall              : backpressure from the pool stage
//   window_valid/window       : flattened window (element i at [i*32 +: 32])
//   frame_done                : pulse after the last pixel of a frame
interface cnn_pool_window_if;
  import cnn_pool_window_pkg::*;
  logic                in_valid;
  pix_t                in_data;
  logic                in_ready;
  logic                window_stall;
  logic                window_valid;
  logic [WS*PIX_W-1:0] window;
  logic                frame_done;

  modport master (output in_valid, in_data, window_stall,
                  input  in_ready, window_valid, window, frame_done);
  modport slave  (input  in_valid, in_data, window_stall,
                  output in_ready, window_valid, window, frame_done);
endinterface

// File: rtl/cnn_line_buffer.sv
// cnn_line_buffer: two MAX_WIDTH-deep pixel rows sharing one address.
//   clk  : clock          en   : write enable (pixel accepted)
//   addr : column         din  : incoming pixel (row r)
//   prev1: row r-1 pixel  prev2: row r-2 pixel (both read before the write)
// Contents are intentionally not reset.
module cnn_line_buffer
  import cnn_pool_window_pkg::*;
#(
  parameter int MAX_WIDTH = `POOL_LB_MAX_WIDTH,
  parameter int AW        = `POOL_DIM_W
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  pix_t          din,
  output pix_t          prev1,
  output pix_t          prev2
);
  pix_t lb0 [MAX_WIDTH];
  pix_t lb1 [MAX_WIDTH];

  // Asynchronous read + clocked write gives read-before-write at one address.
  assign prev1 = lb0[addr];
  assign prev2 = lb1[addr];

  always_ff @(posedge clk) begin
    if (en) begin
      lb1[addr] <= lb0[addr];
      lb0[addr] <= din;
    end
  end
endmodule

// File: rtl/cnn_pool_window.sv
// cnn_pool_window: line-buffer window generator feeding the pooling stage.
//   clk, rst (async, active high)
//   conf_refresh                 : latch config, restart frame counters
//   kernel_height/kernel_width   : one-hot kernel size (2 or 3, must match)
//   fm_width/fm_height           : feature-map size
//   pool_stride                  : only with POOL_WINDOW_STRIDE_EN (0 = kernel size)
//   pw (slave)                   : pixel stream in, window stream out
module cnn_pool_window
  import cnn_pool_window_pkg::*;
#(
  parameter int MAX_WIDTH = `POOL_LB_MAX_WIDTH,
  parameter int DIM_W     = `POOL_DIM_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                conf_refresh,
  input  logic [KS-1:0]       kernel_height,
  input  logic [KS-1:0]       kernel_width,
  input  logic [DIM_W-1:0]    fm_width,
  input  logic [DIM_W-1:0]    fm_height,
`ifdef POOL_WINDOW_STRIDE_EN
  input  logic [STRIDE_W-1:0] pool_stride,
`endif
  cnn_pool_window_if.slave    pw
);
  logic [KS-1:0]       kh_q, kw_q;
  logic [DIM_W-1:0]    w_q, h_q;
`ifdef POOL_WINDOW_STRIDE_EN
  logic [STRIDE_W-1:0] stride_q;
`endif
  logic [DIM_W-1:0]    row, col;
  logic [STRIDE_W-1:0] rph, cph;
  col_t [1:0]          hist;       // two most recent columns, [0] oldest
  col_t [2:0]          cols_nxt;   // window columns including the incoming one
  col_t                new_col;
  pix_t [WS-1:0]       win_nxt;
  pix_t                prev1, prev2;
  logic [1:0]          kh_dim, kw_dim;
  logic [DIM_W-1:0]    k, km1;
  logic [STRIDE_W-1:0] s, sm1;
  logic                accept, cfg_ok, complete, last_col, last_row;

  assign pw.in_ready = ~pw.window_stall & ~conf_refresh & ~rst;
  assign accept      = pw.in_valid & pw.in_ready;

  assign kh_dim = kdim(kh_q);
  assign kw_dim = kdim(kw_q);
  assign cfg_ok = (kh_dim != 2'd0) && (kh_dim == kw_dim);
  assign k      = DIM_W'(kh_dim);
  assign km1    = k - DIM_W'(1);
`ifdef POOL_WINDOW_STRIDE_EN
  assign s      = (stride_q == '0) ? STRIDE_W'(kh_dim) : stride_q;
`else
  assign s      = STRIDE_W'(kh_dim);
`endif
  assign sm1    = s - STRIDE_W'(1);

  assign last_col = (col == w_q - DIM_W'(1));
  assign last_row = (row == h_q - DIM_W'(1));
  assign complete = accept && cfg_ok && (row >= km1) && (col >= km1) &&
                    (rph == '0) && (cph == '0);

  cnn_line_buffer #(.MAX_WIDTH(MAX_WIDTH), .AW(DIM_W)) u_lb (
    .clk   (clk),
    .en    (accept),
    .addr  (col),
    .din   (pw.in_data),
    .prev1 (prev1),
    .prev2 (prev2)
  );

  assign new_col  = {pw.in_data, prev1, prev2};
  assign cols_nxt = {new_col, hist[1], hist[0]};

  // Window is built from the columns as they will be after this accept, so
  // the completing pixel lands in the registered window one cycle later.
  always_comb begin
    win_nxt = '0;
    if (kh_dim == 2'd3) begin
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 3; x++)
          win_nxt[y*3+x] = cols_nxt[x][y];
    end else begin
      for (int y = 0; y < 2; y++)
        for (int x = 0; x < 2; x++)
          win_nxt[y*2+x] = cols_nxt[x+1][y+1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kh_q            <= '0;
      kw_q            <= '0;
      w_q             <= '0;
      h_q             <= '0;
`ifdef POOL_WINDOW_STRIDE_EN
      stride_q        <= '0;
`endif
      row             <= '0;
      col             <= '0;
      rph             <= '0;
      cph             <= '0;
      hist            <= '0;
      pw.window_valid <= 1'b0;
      pw.window       <= '0;
      pw.frame_done   <= 1'b0;
    end else if (conf_refresh) begin
      kh_q            <= kernel_height;
      kw_q            <= kernel_width;
      w_q             <= fm_width;
      h_q             <= fm_height;
`ifdef POOL_WINDOW_STRIDE_EN
      stride_q        <= pool_stride;
`endif
      row             <= '0;
      col             <= '0;
      rph             <= '0;
      cph             <= '0;
      pw.window_valid <= 1'b0;
      pw.frame_done   <= 1'b0;
    end else if (!pw.window_stall) begin
      pw.window_valid <= complete;
      if (complete) pw.window <= win_nxt;
      pw.frame_done   <= accept & last_col & last_row;
      if (accept) begin
        hist <= cols_nxt[2:1];
        if (last_col) begin
          col <= '0;
          cph <= '0;
          if (last_row) begin
            row <= '0;
            rph <= '0;
          end else begin
            row <= row + DIM_W'(1);
            // Phase stays 0 until the first window row, then counts mod stride.
            rph <= (row < km1 || rph == sm1) ? '0 : rph + STRIDE_W'(1);
          end
        end else begin
          col <= col + DIM_W'(1);
          cph <= (col < km1 || cph == sm1) ? '0 : cph + STRIDE_W'(1);
        end
      end
    end
  end
endmodule
